// File: rtl/discipline_ctrl.sv
// GPS 1PPS disciplining controller: steers the OCXO PWM duty from phase measurements,
// realigns the local 1PPS divider on coarse errors and falls back to holdover when GPS goes quiet.
module discipline_ctrl #(
    parameter int unsigned DUTY_CENTER = 32768,
    parameter int unsigned DUTY_MIN    = 16384,
    parameter int unsigned DUTY_MAX    = 49152,
    parameter int unsigned COARSE_TH   = 10,
    parameter int unsigned FINE_TH     = 2,
    parameter int unsigned STEP        = 256,
    parameter int unsigned LOCK_CNT    = 8,
    parameter int unsigned TIMEOUT_CYC = 15000000
) (
    input  logic        CLK_SYS,
    input  logic        CLK_RST,
    input  logic        MEAS_VALID,
    input  logic        MEAS_LEAD,
    input  logic [31:0] MEAS_PHASE,
    output logic [31:0] PWM_Duty,
    output logic        DIV_RESET,
    output logic        LED_Lock,
    output logic [2:0]  STATE
);

    localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ALIGN    = 3'd1,
        SETTLE   = 3'd2,
        TRACK    = 3'd3,
        LOCKED   = 3'd4,
        HOLDOVER = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic [31:0]     duty, duty_nxt, duty_corr;
    logic [GW-1:0]   good_cnt, good_nxt;
    logic [31:0]     tmo_cnt;
    logic [32:0]     sum;
    logic            coarse, fine, tmo_hit;

    assign coarse  = MEAS_PHASE > COARSE_TH;
    assign fine    = !coarse && (MEAS_PHASE > FINE_TH);
    // Expiry fires on the edge that would carry the counter to TIMEOUT_CYC.
    assign tmo_hit = tmo_cnt >= (TIMEOUT_CYC - 1);

    // 33-bit correction: bit 32 catches both a borrow below zero and a carry past 2^32.
    always_comb begin
        if (MEAS_LEAD) sum = {1'b0, duty} - 33'(STEP);
        else           sum = {1'b0, duty} + 33'(STEP);
        if (MEAS_LEAD && sum[32])      duty_corr = DUTY_MIN;
        else if (sum > 33'(DUTY_MAX))  duty_corr = DUTY_MAX;
        else if (sum < 33'(DUTY_MIN))  duty_corr = DUTY_MIN;
        else                           duty_corr = sum[31:0];
    end

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        good_nxt  = good_cnt;
        case (state)
            IDLE, HOLDOVER: begin
                if (MEAS_VALID) begin
                    good_nxt  = '0;
                    state_nxt = coarse ? ALIGN : TRACK;
                end
            end
            ALIGN: state_nxt = SETTLE;
            SETTLE: begin
                if (MEAS_VALID) begin
                    state_nxt = TRACK;
                    good_nxt  = '0;
                end else if (tmo_hit) begin
                    state_nxt = HOLDOVER;
                end
            end
            TRACK, LOCKED: begin
                if (MEAS_VALID) begin
                    if (coarse) begin
                        state_nxt = ALIGN;
                    end else if (fine) begin
                        duty_nxt  = duty_corr;
                        good_nxt  = '0;
                        state_nxt = TRACK;
                    end else if (state == TRACK) begin
                        good_nxt = good_cnt + GW'(1);
                        if (good_nxt == GW'(LOCK_CNT)) state_nxt = LOCKED;
                    end
                end else if (tmo_hit) begin
                    state_nxt = HOLDOVER;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            state     <= IDLE;
            duty      <= DUTY_CENTER;
            good_cnt  <= '0;
            tmo_cnt   <= '0;
            DIV_RESET <= 1'b0;
            LED_Lock  <= 1'b1;
        end else begin
            state     <= state_nxt;
            duty      <= duty_nxt;
            good_cnt  <= good_nxt;
            // ALIGN lasts one cycle, so the pulse covers exactly that cycle.
            DIV_RESET <= (state_nxt == ALIGN);
            LED_Lock  <= (state_nxt != LOCKED);
            if (MEAS_VALID)                tmo_cnt <= '0;
            else if (tmo_cnt < TIMEOUT_CYC) tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign PWM_Duty = duty;
    assign STATE    = state;

endmodule

// File: tb/tb_discipline_ctrl.sv
// Scoreboard bench for discipline_ctrl: an integer reference model predicts each response,
// a negedge monitor pops and compares the cycle after every measurement or timeout.
module tb_discipline_ctrl;

    localparam int unsigned TMO  = 64;
    localparam int unsigned C_TH = 10;
    localparam int unsigned F_TH = 2;
    localparam int unsigned STP  = 256;
    localparam int unsigned LK   = 8;
    localparam longint      CEN  = 32768;
    localparam longint      DMIN = 16384;
    localparam longint      DMAX = 49152;

    logic        CLK_SYS = 1'b0;
    logic        CLK_RST = 1'b0;
    logic        meas_valid = 1'b0;
    logic        meas_lead = 1'b0;
    logic [31:0] meas_phase = '0;
    logic [31:0] pwm_duty;
    logic        div_reset, led_lock;
    logic [2:0]  state;

    discipline_ctrl #(
        .DUTY_CENTER(32768), .DUTY_MIN(16384), .DUTY_MAX(49152),
        .COARSE_TH(C_TH), .FINE_TH(F_TH), .STEP(STP), .LOCK_CNT(LK), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK_SYS(CLK_SYS), .CLK_RST(CLK_RST), .MEAS_VALID(meas_valid), .MEAS_LEAD(meas_lead),
        .MEAS_PHASE(meas_phase), .PWM_Duty(pwm_duty), .DIV_RESET(div_reset),
        .LED_Lock(led_lock), .STATE(state)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    typedef struct {
        int     st;
        longint duty;
        bit     led;
        bit     div;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;
    bit   exp_flag = 0, chk = 0;
    int   div_seen = 0, div_exp = 0;

    // Reference model: state codes 0..5, duty as a plain integer
    int     m_st, m_good, m_idle;
    longint m_duty;

    function automatic void m_reset();
        m_st = 0; m_duty = CEN; m_good = 0; m_idle = 0;
    endfunction

    function automatic void push();
        exp_t e;
        e.st = m_st; e.duty = m_duty; e.led = (m_st != 4); e.div = (m_st == 1);
        q.push_back(e);
        exp_flag = 1;
    endfunction

    function automatic void model(input bit mv, input bit ld, input logic [31:0] ph);
        longint d;
        if (mv) begin
            m_idle = 0;
            case (m_st)
                0, 5: begin m_good = 0; m_st = (ph > C_TH) ? 1 : 3; end
                1: m_st = 2;
                2: begin m_st = 3; m_good = 0; end
                default: begin
                    if (ph > C_TH) m_st = 1;
                    else if (ph > F_TH) begin
                        d = ld ? m_duty - STP : m_duty + STP;
                        m_duty = (d > DMAX) ? DMAX : (d < DMIN) ? DMIN : d;
                        m_good = 0; m_st = 3;
                    end else if (m_st == 3) begin
                        m_good++;
                        if (m_good == LK) m_st = 4;
                    end
                end
            endcase
            if (m_st == 1) div_exp++;
            push();
        end else begin
            m_idle++;
            if (m_st == 1) m_st = 2;
            else if (m_st >= 2 && m_st <= 4 && m_idle >= TMO) begin
                m_st = 5;
                push();
            end
        end
    endfunction

    task automatic tick(input bit mv, input bit ld, input logic [31:0] ph);
        meas_valid = mv;
        meas_lead  = mv ? ld : 1'($urandom);
        meas_phase = mv ? ph : $urandom;
        model(mv, ld, ph);
        @(posedge CLK_SYS); #1;
        meas_valid = 1'b0;
        exp_flag   = 0;
    endtask

    task automatic meas(input bit ld, input logic [31:0] ph, input int gap);
        tick(1'b1, ld, ph);
        for (int i = 0; i < gap; i++) tick(1'b0, 1'b0, 32'd0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(posedge CLK_SYS) chk <= exp_flag;

    always @(negedge CLK_SYS) if (div_reset === 1'b1) div_seen++;

    always @(negedge CLK_SYS) begin
        if (chk) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard: DUT response with no expectation queued");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (state !== 3'(e.st) || pwm_duty !== 32'(e.duty) ||
                    led_lock !== e.led || div_reset !== e.div) begin
                    failures++;
                    $display("FAIL scoreboard @%0t: state=%0d duty=%0d led=%b div=%b expected state=%0d duty=%0d led=%b div=%b",
                             $time, state, pwm_duty, led_lock, div_reset, e.st, e.duty, e.led, e.div);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ph;
        int gap;
        m_reset();
        repeat (3) @(posedge CLK_SYS);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_duty", pwm_duty, 32'(CEN));
        check("reset_div", 32'(div_reset), 32'd0);
        check("reset_led", 32'(led_lock), 32'd1);
        CLK_RST = 1'b1;

        // No state change without a measurement, even over a long quiet stretch
        for (int i = 0; i < TMO + 5; i++) tick(1'b0, 1'b0, 32'd0);
        check("idle_hold", 32'(state), 32'd0);

        // Coarse error -> ALIGN with one DIV_RESET pulse -> SETTLE, first measurement discarded
        meas(1'b0, 32'd50, 1);
        check("settle_state", 32'(state), 32'd2);
        check("settle_div", 32'(div_reset), 32'd0);
        meas(1'b0, 32'd5, 1);

        // Fine corrections in both directions, then lock and unlock
        for (int i = 0; i < 3; i++) meas(1'b0, 32'd5, 1);
        meas(1'b1, 32'd5, 1);
        for (int i = 0; i < 8; i++) meas(1'(i), 32'd1, 1);
        meas(1'b1, 32'd4, 1);

        // Saturation at both clamps
        for (int i = 0; i < 70; i++) meas(1'b0, 32'd5, 1);
        for (int i = 0; i < 140; i++) meas(1'b1, 32'd7, 1);

        // Lock again, measurement on the expiry cycle wins, then a real timeout
        for (int i = 0; i < 8; i++) meas(1'b0, 32'd2, 1);
        meas(1'b0, 32'd1, TMO - 1);
        meas(1'b0, 32'd1, TMO + 3);
        check("holdover_state", 32'(state), 32'd5);
        meas(1'b0, 32'd3, 2);

        // Reset asserted in the middle of the DIV_RESET pulse
        meas(1'b0, 32'd50, 0);
        @(negedge CLK_SYS); #1;
        CLK_RST = 1'b0;
        #1;
        check("rst_mid_div", 32'(div_reset), 32'd0);
        check("rst_mid_state", 32'(state), 32'd0);
        check("rst_mid_led", 32'(led_lock), 32'd1);
        check("rst_mid_duty", pwm_duty, 32'(CEN));
        @(posedge CLK_SYS); #1;
        m_reset();
        CLK_RST = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'd0);
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_duty", pwm_duty, 32'(CEN));

        // Randomized traffic with boundary-heavy phases and gaps around the timeout
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: ph = $urandom_range(0, F_TH);
                6:                ph = $urandom_range(F_TH + 1, C_TH);
                7:                ph = ($urandom_range(0, 1) == 0) ? 32'(F_TH + 1) : 32'(C_TH);
                8:                ph = $urandom_range(C_TH + 1, 5000);
                default:          ph = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: gap = 0;
                1: gap = 1;
                2: gap = 2;
                3: gap = 3;
                4: gap = TMO - 1;
                5: gap = TMO;
                default: gap = TMO + 5;
            endcase
            meas(1'($urandom), ph, gap);
        end

        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'd0);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("div_pulse_cycles", 32'(div_seen), 32'(div_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/discipline_ctrl.md
DISCIPLINE_CTRL -- requirements
Module: discipline_ctrl

Parameters
REQ-001 SHALL provide DUTY_CENTER, default 32768, power-up/neutral OCXO PWM duty.
REQ-002 SHALL provide DUTY_MIN, default 16384, lower duty clamp.
REQ-003 SHALL provide DUTY_MAX, default 49152, upper duty clamp.
REQ-004 SHALL provide COARSE_TH, default 10, phase counts above which the divider is realigned.
REQ-005 SHALL provide FINE_TH, default 2, phase counts at or below which a second counts as good.
REQ-006 SHALL provide STEP, default 256, duty correction per bad second.
REQ-007 SHALL provide LOCK_CNT, default 8, consecutive good seconds needed for lock.
REQ-008 SHALL provide TIMEOUT_CYC, default 15000000, CLK_SYS cycles without a measurement before GPS is declared lost.

Interface
REQ-009 CLK_SYS  in  1  system clock, also the disciplined OCXO clock.
REQ-010 CLK_RST  in  1  reset, asynchronous, active-low.
REQ-011 MEAS_VALID  in  1  one-cycle strobe: a GPS/local 1PPS phase measurement is complete.
REQ-012 MEAS_LEAD  in  1  0 = GPS leads, 1 = local leads; sampled with MEAS_VALID.
REQ-013 MEAS_PHASE  in  32  unsigned phase difference in CLK_SYS counts; sampled with MEAS_VALID.
REQ-014 PWM_Duty  out  32  registered duty word to the PWM generator.
REQ-015 DIV_RESET  out  1  one-cycle pulse that restarts the local 1PPS divider.
REQ-016 LED_Lock  out  1  lock indicator, active-low (0 = locked).
REQ-017 STATE  out  3  current FSM state code.

Function
REQ-018 The FSM SHALL use states IDLE=0, ALIGN=1, SETTLE=2, TRACK=3, LOCKED=4 and HOLDOVER=5.
REQ-019 IDLE and HOLDOVER on MEAS_VALID SHALL go to ALIGN if MEAS_PHASE>COARSE_TH, else to TRACK with good_cnt=0.
REQ-020 ALIGN SHALL assert DIV_RESET for exactly one cycle, the cycle after entry, and then go to SETTLE.
REQ-021 SETTLE SHALL discard the first MEAS_VALID, leave duty unchanged, and go to TRACK with good_cnt=0.
REQ-022 In TRACK, on MEAS_VALID with MEAS_PHASE>COARSE_TH, the FSM SHALL go to ALIGN with duty unchanged.
REQ-023 In TRACK, on MEAS_VALID with FINE_TH<MEAS_PHASE<=COARSE_TH, the block SHALL add STEP to duty when MEAS_LEAD=0, subtract STEP when MEAS_LEAD=1, and clear good_cnt.
REQ-024 In TRACK, on MEAS_VALID with MEAS_PHASE<=FINE_TH, good_cnt SHALL increment with duty unchanged; when good_cnt reaches LOCK_CNT the FSM SHALL go to LOCKED.
REQ-025 In LOCKED, a MEAS_PHASE<=FINE_TH measurement SHALL keep the state; FINE_TH<MEAS_PHASE<=COARSE_TH SHALL apply the REQ-023 correction and return to TRACK with good_cnt=0; MEAS_PHASE>COARSE_TH SHALL go to ALIGN.
REQ-026 PWM_Duty SHALL update exactly one CLK_SYS cycle after the MEAS_VALID cycle.
REQ-027 The duty sum SHALL be computed at 33 bits and saturated to [DUTY_MIN, DUTY_MAX], with no wrap.
REQ-028 LED_Lock SHALL be 0 only in LOCKED, registered, and SHALL change in the same cycle as the state transition.
REQ-029 The timeout counter SHALL clear on every MEAS_VALID, increment otherwise, and saturate at TIMEOUT_CYC.
REQ-030 In SETTLE, TRACK or LOCKED, reaching TIMEOUT_CYC SHALL move the FSM to HOLDOVER with PWM_Duty frozen at its last value.
REQ-031 IDLE, ALIGN and HOLDOVER SHALL NOT time out.
REQ-032 When MEAS_VALID and timeout expiry coincide, MEAS_VALID SHALL win and the timeout SHALL be ignored.
REQ-033 MEAS_VALID in ALIGN SHALL be ignored.
REQ-034 MEAS_LEAD SHALL be ignored when MEAS_PHASE<=FINE_TH.

Reset
REQ-035 While CLK_RST=0, the block SHALL hold STATE=IDLE, PWM_Duty=DUTY_CENTER, DIV_RESET=0, LED_Lock=1, good_cnt=0 and timeout counter=0.
REQ-036 Reset assertion mid-operation, including mid-DIV_RESET pulse, SHALL take effect immediately, with no pending duty update after release.
REQ-037 The first state change after reset release SHALL require a MEAS_VALID.

Verification
REQ-038 Reset release, then MEAS_VALID with PHASE=50 and LEAD=0 -> ALIGN, then exactly one DIV_RESET pulse, then SETTLE; the next MEAS_VALID is discarded -> TRACK with duty 32768.
REQ-039 In TRACK, three MEAS_VALIDs with PHASE=5, LEAD=0 -> duty 33024, 33280, 33536; then PHASE=5, LEAD=1 -> 33280.
REQ-040 In TRACK, eight consecutive MEAS_VALIDs with PHASE=1 -> LOCKED and LED_Lock=0 after the eighth; a following PHASE=4, LEAD=1 -> TRACK, LED_Lock=1, duty -256.
REQ-041 Duty at 49152 with PHASE=5, LEAD=0 -> stays 49152; duty at 16384 with LEAD=1 -> stays 16384.
REQ-042 In LOCKED, no MEAS_VALID for 15000000 cycles -> HOLDOVER with duty unchanged and LED_Lock=1; MEAS_VALID on the expiry cycle with PHASE=1 -> stays LOCKED.
REQ-043 In HOLDOVER, MEAS_VALID with PHASE=3 -> TRACK with no DIV_RESET; reset asserted during a DIV_RESET pulse -> DIV_RESET=0 immediately and STATE=IDLE.
